bram_fifo_sync: RTL

Single-clock FIFO controller that drives a `bram_sync_dp` instance, with port A as the write port and port B as the read port, and presents its contents as a first-word-fall-through valid/ready stream. It sits directly in front of the BRAM. It owns both BRAM address ports, handles the BRAM's 1-cycle read latency with an in-flight flag and a 2-entry output buffer, and sustains 1 word/cycle in both directions.

---
 rtl/bram_fifo_sync.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bram_fifo_sync.sv
// First-word-fall-through FIFO controller in front of a 1-cycle-latency dual-port BRAM.
// Port A writes and port B reads. A 2-entry output buffer hides the read latency.
module bram_fifo_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_a_wr,
  output logic [ADDR_WIDTH-1:0] ram_a_addr,
  output logic [DATA_WIDTH-1:0] ram_a_data_in,
  output logic [ADDR_WIDTH-1:0] ram_b_addr,
  input  logic [DATA_WIDTH-1:0] ram_b_data_out
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  overflow_q, overflow_d;

  logic       wr_acc;
  logic       rd_iss;
  logic       pop;
  logic [2:0] occ_after_pop;

  assign full       = (ram_cnt_q == DEPTH);
  assign overflow   = overflow_q;
  assign dout       = head_q;
  assign dout_valid = (buf_cnt_q != 2'd0);
  assign count      = (ADDR_WIDTH+2)'(ram_cnt_q) + (ADDR_WIDTH+2)'(inflight_q)
                    + (ADDR_WIDTH+2)'(buf_cnt_q);

  assign pop    = dout_valid && dout_ready;
  assign wr_acc = wr_en && !full && !rst;

  // Issue only if the word will still have a buffer slot when it lands next cycle.
  assign occ_after_pop = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_iss        = (ram_cnt_q != '0) && (occ_after_pop < 3'd2) && !rst;

  assign ram_a_wr      = wr_acc;
  assign ram_a_addr    = wr_ptr_q;
  assign ram_a_data_in = wr_data;
  assign ram_b_addr    = rd_ptr_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = rd_iss;
    overflow_d = overflow_q | (wr_en & full);

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_iss) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_acc, rd_iss})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  // Output buffer: a capture appends at the tail, a pop shifts the tail into the head.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    buf_cnt_d = buf_cnt_q;

    case ({inflight_q, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) head_d = ram_b_data_out;
        else                   tail_d = ram_b_data_out;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        head_d    = tail_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          head_d = ram_b_data_out;
        end else begin
          head_d = tail_q;
          tail_d = ram_b_data_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
